// File: rtl/cmp2_share_ctrl_pkg.sv
// Shared definitions for the two-requester serial equality engine:
// FSM state encoding, requester indices and a grant helper.
package cmp2_share_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CMP  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam logic REQ_ID0 = 1'b0;
    localparam logic REQ_ID1 = 1'b1;

    // One-hot grant vector for a requester index.
    function automatic logic [1:0] id_to_gnt(input logic id);
        return (id == REQ_ID1) ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/cmp2_share_ctrl_eq2.sv
// eq2: existing 2-bit equality comparator, reused as-is.
module eq2 (
    input  logic [1:0] a,
    input  logic [1:0] b,
    output logic       eq
);

    assign eq = (a == b);

endmodule

// File: rtl/cmp2_share_ctrl.sv
// cmp2_share_ctrl: one eq2 comparator shared round-robin between two
// requesters. The winner's operands are latched and walked two bits per
// cycle, LSB slice first, stopping at the first mismatching slice.
module cmp2_share_ctrl
    import cmp2_share_ctrl_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       req,
    input  logic [WIDTH-1:0] a0,
    input  logic [WIDTH-1:0] b0,
    input  logic [WIDTH-1:0] a1,
    input  logic [WIDTH-1:0] b1,
    output logic [1:0]       gnt,
    output logic             busy,
    output logic             done,
    output logic             done_id,
    output logic             aeqb
);

    localparam int SLICES = WIDTH / 2;
    localparam int IDX_W  = (SLICES > 1) ? $clog2(SLICES) : 1;

    state_e             state_q, state_d;
    logic               last_q, last_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [1:0]         gnt_q, gnt_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               done_id_q, done_id_d;
    logic               aeqb_q, aeqb_d;

    logic               win_id;
    logic [1:0]         a_sl [SLICES];
    logic [1:0]         b_sl [SLICES];
    logic [1:0]         cur_a;
    logic [1:0]         cur_b;
    logic               slice_eq;

    // Split the latched operands into 2-bit slices for the serial walk.
    for (genvar gi = 0; gi < SLICES; gi++) begin : g_slice
        assign a_sl[gi] = a_q[2*gi +: 2];
        assign b_sl[gi] = b_q[2*gi +: 2];
    end

    assign cur_a = a_sl[idx_q];
    assign cur_b = b_sl[idx_q];

    eq2 u_eq2 (
        .a  (cur_a),
        .b  (cur_b),
        .eq (slice_eq)
    );

    // Round-robin: a lone request wins outright; on a tie the requester
    // that did not win last time goes next.
    assign win_id = (req == 2'b11) ? ~last_q : req[1];

    // Next-state and registered-output logic.
    always_comb begin
        state_d   = state_q;
        last_d    = last_q;
        idx_d     = idx_q;
        a_d       = a_q;
        b_d       = b_q;
        gnt_d     = gnt_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        done_id_d = done_id_q;
        aeqb_d    = aeqb_q;
        case (state_q)
            ST_IDLE: begin
                if (req != 2'b00) begin
                    last_d  = win_id;
                    idx_d   = '0;
                    a_d     = (win_id == REQ_ID1) ? a1 : a0;
                    b_d     = (win_id == REQ_ID1) ? b1 : b0;
                    gnt_d   = id_to_gnt(win_id);
                    busy_d  = 1'b1;
                    state_d = ST_CMP;
                end
            end
            ST_CMP: begin
                if (!slice_eq) begin
                    aeqb_d    = 1'b0;
                    done_d    = 1'b1;
                    done_id_d = last_q;
                    state_d   = ST_DONE;
                end else if (idx_q == IDX_W'(SLICES - 1)) begin
                    aeqb_d    = 1'b1;
                    done_d    = 1'b1;
                    done_id_d = last_q;
                    state_d   = ST_DONE;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            ST_DONE: begin
                gnt_d   = 2'b00;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                gnt_d   = 2'b00;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset clears everything and re-arms
    // the pointer so requester 0 wins the first tie.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            last_q    <= REQ_ID1;
            idx_q     <= '0;
            a_q       <= '0;
            b_q       <= '0;
            gnt_q     <= 2'b00;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            done_id_q <= 1'b0;
            aeqb_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            last_q    <= last_d;
            idx_q     <= idx_d;
            a_q       <= a_d;
            b_q       <= b_d;
            gnt_q     <= gnt_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            done_id_q <= done_id_d;
            aeqb_q    <= aeqb_d;
        end
    end

    assign gnt     = gnt_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign done_id = done_id_q;
    assign aeqb    = aeqb_q;

endmodule

// File: tb/tb_cmp2_share_ctrl.sv
// Self-checking bench for cmp2_share_ctrl (WIDTH=8): directed jobs from
// the test plan followed by randomized jobs against a job-level model.
module tb_cmp2_share_ctrl;

    localparam int W = 8;
    localparam int S = W / 2;

    logic         clk;
    logic         reset_n;
    logic [1:0]   req;
    logic [W-1:0] a0, b0, a1, b1;
    logic [1:0]   gnt;
    logic         busy, done, done_id, aeqb;

    int n_checks = 0;
    int n_pass   = 0;
    int job_no   = 0;

    // reference model state
    logic model_last;
    logic model_aeqb;
    logic model_did;

    cmp2_share_ctrl #(.WIDTH(W)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .req     (req),
        .a0      (a0),
        .b0      (b0),
        .a1      (a1),
        .b1      (b1),
        .gnt     (gnt),
        .busy    (busy),
        .done    (done),
        .done_id (done_id),
        .aeqb    (aeqb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s (job %0d): observed %0h, expected %0h", tag, job_no, obs, exp);
    endtask

    // Cycle (relative to request sample) at which done is expected:
    // first unequal 2-bit slice k gives k+2, all equal gives S+1.
    function automatic int exp_latency(input logic [W-1:0] x, input logic [W-1:0] y);
        for (int k = 0; k < S; k++) begin
            if (x[2*k +: 2] != y[2*k +: 2]) return k + 2;
        end
        return S + 1;
    endfunction

    task automatic idle(input int cycles);
        req = 2'b00;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk); #1;
            chk("idle_gnt", gnt, 2'b00);
            chk("idle_busy", busy, 1'b0);
            chk("idle_done", done, 1'b0);
            chk("idle_aeqb_hold", aeqb, model_aeqb);
            chk("idle_did_hold", done_id, model_did);
        end
    endtask

    // Run one job starting from an IDLE cycle; returns in the IDLE cycle
    // following DONE.
    task automatic do_job(input logic [1:0] r, input logic [W-1:0] xa0, input logic [W-1:0] xb0,
                          input logic [W-1:0] xa1, input logic [W-1:0] xb1,
                          input bit scramble, input bit drop0);
        logic         winner;
        logic [W-1:0] ea, eb;
        logic [1:0]   eg;
        logic         eq;
        int           lat;
        job_no++;
        req = r; a0 = xa0; b0 = xb0; a1 = xa1; b1 = xb1;
        winner = (r == 2'b11) ? ~model_last : r[1];
        ea  = winner ? xa1 : xa0;
        eb  = winner ? xb1 : xb0;
        eq  = (ea == eb);
        lat = exp_latency(ea, eb);
        eg  = winner ? 2'b10 : 2'b01;
        model_last = winner;
        for (int n = 1; n <= lat + 1; n++) begin
            @(posedge clk); #1;
            if (n == 1 && scramble) begin
                a0 = W'($urandom); b0 = W'($urandom);
                a1 = W'($urandom); b1 = W'($urandom);
                req = 2'($urandom_range(0, 3));
            end
            if (n == 2 && drop0) req[0] = 1'b0;
            chk("gnt", gnt, (n <= lat) ? eg : 2'b00);
            chk("busy", busy, (n <= lat) ? 1'b1 : 1'b0);
            chk("done", done, (n == lat) ? 1'b1 : 1'b0);
            if (n >= lat) begin
                chk("aeqb", aeqb, eq);
                chk("done_id", done_id, winner);
            end
        end
        model_aeqb = eq;
        model_did  = winner;
        $display("job %0d req=%b winner=%0d a=%h b=%h aeqb=%0d done_at=T%0d",
                 job_no, r, winner, ea, eb, eq, lat);
    endtask

    task automatic rand_pair(output logic [W-1:0] x, output logic [W-1:0] y);
        int k;
        x = W'($urandom);
        y = x;
        if ($urandom_range(0, 2) != 0) begin
            k = $urandom_range(0, S - 1);
            y[2*k +: 2] = y[2*k +: 2] ^ 2'($urandom_range(1, 3));
        end
    endtask

    initial begin
        logic [W-1:0] ra0, rb0, ra1, rb1;
        logic [1:0]   rr;
        reset_n = 1'b0;
        req = 2'b00; a0 = '0; b0 = '0; a1 = '0; b1 = '0;
        model_last = 1'b1; model_aeqb = 1'b0; model_did = 1'b0;

        // reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_gnt", gnt, 2'b00);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_did", done_id, 1'b0);
        chk("rst_aeqb", aeqb, 1'b0);
        @(negedge clk) reset_n = 1'b1;
        idle(1);

        // directed: full-length equal compare, slice-0 and slice-3 mismatch
        do_job(2'b01, 8'hA5, 8'hA5, 8'h00, 8'h00, 1'b0, 1'b0);
        idle(1);
        do_job(2'b10, 8'h00, 8'h00, 8'h3C, 8'h3D, 1'b0, 1'b0);
        idle(1);
        do_job(2'b10, 8'h00, 8'h00, 8'h3C, 8'h7C, 1'b0, 1'b0);
        idle(1);

        // reset asserted at T3 of a job
        job_no++;
        req = 2'b01; a0 = 8'h5A; b0 = 8'h5A;
        for (int n = 1; n <= 3; n++) begin
            @(posedge clk); #1;
            chk("rstjob_gnt", gnt, 2'b01);
            chk("rstjob_busy", busy, 1'b1);
            chk("rstjob_done", done, 1'b0);
        end
        reset_n = 1'b0;
        #1;
        chk("async_gnt", gnt, 2'b00);
        chk("async_busy", busy, 1'b0);
        chk("async_done", done, 1'b0);
        chk("async_aeqb", aeqb, 1'b0);
        chk("async_did", done_id, 1'b0);
        req = 2'b11; a0 = 8'h11; b0 = 8'h11; a1 = 8'h22; b1 = 8'h22;
        @(posedge clk); #1;
        chk("inrst_gnt", gnt, 2'b00);
        chk("inrst_done", done, 1'b0);
        $display("job %0d req=01 aborted by reset", job_no);
        @(negedge clk) reset_n = 1'b1;
        model_last = 1'b1; model_aeqb = 1'b0; model_did = 1'b0;

        // req=11 held: first grant to 0, then alternating
        for (int j = 0; j < 4; j++) begin
            ra0 = W'($urandom); ra1 = W'($urandom);
            do_job(2'b11, ra0, ra0, ra1, ra1, 1'b0, 1'b0);
        end
        idle(1);

        // req[0] dropped mid-job: done still issued, no fresh grant to 0
        rand_pair(ra0, rb0);
        do_job(2'b01, ra0, rb0, 8'h00, 8'h00, 1'b0, 1'b1);
        idle(2);

        // randomized jobs with mid-job input churn
        for (int j = 0; j < 40; j++) begin
            rand_pair(ra0, rb0);
            rand_pair(ra1, rb1);
            rr = 2'($urandom_range(1, 3));
            do_job(rr, ra0, rb0, ra1, rb1, 1'b1, 1'b0);
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
        end
        idle(1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/cmp2_share_ctrl.md
Name: cmp2_share_ctrl

Overview:
- Serial equality engine shared between two requesters.
- Holds one instance of the team's existing eq2 2-bit comparator.
- Grants the comparator to one requester at a time (round-robin) and latches that requester's WIDTH-bit operands.
- Walks the operands 2 bits per cycle, LSB slice first, exits early on the first mismatching slice, then reports the result with a done pulse.

Parameters:
- WIDTH, 8, operand width in bits. Must be even and >= 2.
- SLICES, WIDTH/2, derived localparam: number of 2-bit slices.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- req  in  2  request per requester; req[i] high means requester i wants a compare.
- a0  in  WIDTH  requester 0 operand A.
- b0  in  WIDTH  requester 0 operand B.
- a1  in  WIDTH  requester 1 operand A.
- b1  in  WIDTH  requester 1 operand B.
- gnt  out  2  one-hot grant; high from capture until the done cycle.
- busy  out  1  high in CMP and DONE states.
- done  out  1  single-cycle pulse; result valid.
- done_id  out  1  index of the requester whose job finished.
- aeqb  out  1  compare result (1 means equal); holds until the next done.

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-low (reset_n).
- All outputs are registered.
- Reset (async assert, sync release):
  - state=IDLE, gnt=2'b00, busy=0, done=0, done_id=0, aeqb=0, slice index=0.
  - Round-robin pointer last=1, so requester 0 wins the first tie.
- FSM states: IDLE, CMP, DONE.
- IDLE:
  - If req==0: stay in IDLE.
  - If exactly one req bit is set: that requester wins.
  - If both are set: the requester != last wins.
  - On a win: latch the winner's a/b into internal regs, set gnt[winner]=1, last<=winner, idx<=0, go to CMP.
- CMP:
  - Drive latched a[2*idx+1:2*idx] and b[2*idx+1:2*idx] into eq2.
  - If eq2 output is 0: result<=0, go to DONE (early exit).
  - Else if idx==SLICES-1: result<=1, go to DONE.
  - Else: idx<=idx+1, stay in CMP.
- DONE:
  - done=1, aeqb=result, done_id=winner, gnt still asserted.
  - Next cycle go to IDLE with gnt=0 and done=0.
- Latency (request seen in IDLE at cycle T0):
  - gnt asserts at T1.
  - All slices equal: done at T(SLICES+1).
  - Mismatch at slice k: done at T(k+2).
- Throughput: one IDLE cycle between consecutive jobs.
- Requester obligations:
  - Operands must be stable in the cycle req is sampled in IDLE; after capture they are don't-care.
  - A requester keeps req high until it sees done with its done_id.
  - req still high in the IDLE cycle after DONE is treated as a new request.
- req deasserted mid-job: ignored; the job completes and done is still issued.
- req changes during CMP/DONE: no effect on the current job.
- Reset mid-job:
  - All outputs clear immediately on reset assertion; the job is discarded with no done pulse.
  - After release, arbitration restarts with last=1.
- aeqb and done_id hold their values outside done cycles.
- gnt is never two-hot.

Decomposition:
- Shared header (included file):
  - State encoding localparams: IDLE=2'd0, CMP=2'd1, DONE=2'd2.
  - Requester index localparams.
- Sub-module: eq2 (existing, reused unchanged), instantiated once with named ports.
- Arbiter logic stays inline; it is too small to split out.

Test Plan:
- WIDTH=8, req=2'b01, a0=b0=8'hA5 -> gnt=01 at T1; done=1 at T5 with aeqb=1, done_id=0; gnt=00 at T6.
- req=2'b10, a1=8'h3C, b1=8'h3D -> slice 0 mismatch; done at T2, aeqb=0, done_id=1.
- req=2'b10, a1=8'h3C, b1=8'h7C -> slice 3 mismatch; done at T5, aeqb=0, busy high T1–T5.
- req=2'b11 held, all operands equal -> first grant to 0 after reset, then grants alternate 0,1,0,1; one idle cycle between done and the next gnt.
- req[0] dropped at T2 during a compare -> done still issued with done_id=0 and correct aeqb; no new grant to 0 afterwards.
- reset_n pulsed low at T3 of a job -> gnt/busy/done/aeqb read 0 before the next edge; no done pulse; after release with req=2'b11 the grant goes to 0.
